// File: rtl/mask_stream_gen.sv
// rtl/mask_stream_gen.sv - synthetic raster source with a rectangular mask for the segmentation back end.
// Optional frame counter output is enabled by defining MASK_STREAM_FRAME_CNT_EN.
module mask_stream_gen #(
  parameter int IMG_W   = 720,
  parameter int IMG_H   = 576,
  parameter int H_BLANK = 144,
  parameter int V_BLANK = 49
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       enable,
  input  logic [9:0] rect_x_min,
  input  logic [9:0] rect_x_max,
  input  logic [9:0] rect_y_min,
  input  logic [9:0] rect_y_max,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       mask,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_done,
  output logic       busy
`ifdef MASK_STREAM_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [9:0] H_LAST     = 10'(IMG_W + H_BLANK - 1);
  localparam logic [9:0] V_LAST     = 10'(IMG_H + V_BLANK - 1);
  localparam logic [9:0] H_ACT      = 10'(IMG_W);
  localparam logic [9:0] V_ACT      = 10'(IMG_H);
  localparam logic [9:0] V_ACT_LAST = 10'(IMG_H - 1);

  state_t     state_q, state_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, mask_q, mask_d;
  logic       frame_done_q, frame_done_d;
  logic       run_d;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    frame_done_d = 1'b0;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_RUN;
            h_d     = '0;
            v_d     = '0;
            xmin_d  = rect_x_min;
            xmax_d  = rect_x_max;
            ymin_d  = rect_y_min;
            ymax_d  = rect_y_max;
          end
        end
        S_RUN: begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              // Frame boundary: the rectangle only ever changes here, never mid-frame.
              v_d = '0;
              if (enable) begin
                xmin_d = rect_x_min;
                xmax_d = rect_x_max;
                ymin_d = rect_y_min;
                ymax_d = rect_y_max;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              v_d          = v_q + 10'd1;
              frame_done_d = (v_q == V_ACT_LAST);
            end
          end else begin
            h_d = h_q + 10'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Outputs decode the next counter values so they register on the same edge.
    run_d   = (state_d == S_RUN);
    hsync_d = run_d && (h_d < H_ACT);
    vsync_d = run_d && (v_d < V_ACT);
    de_d    = hsync_d && vsync_d;
    mask_d  = de_d && (h_d >= xmin_d) && (h_d <= xmax_d) && (v_d >= ymin_d) && (v_d <= ymax_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      de_q         <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      mask_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      de_q         <= de_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign de         = de_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign mask       = mask_q;
  assign x          = h_q;
  assign y          = v_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == S_RUN);

`ifdef MASK_STREAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + 16'(frame_done_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mask_stream_gen.sv
// tb/tb_mask_stream_gen.sv - randomized check of mask_stream_gen against a linear-position frame model.
module tb_mask_stream_gen;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int HB    = 4;
  localparam int VB    = 2;
  localparam int HT    = W + HB;
  localparam int VT    = H + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] rxmin = '0, rxmax = '0, rymin = '0, rymax = '0;
  logic       de, hsync, vsync, mask, frame_done, busy;
  logic [9:0] x, y;
`ifdef MASK_STREAM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  mask_stream_gen #(.IMG_W(W), .IMG_H(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk(clk), .rst(rst), .ce(ce), .enable(enable),
    .rect_x_min(rxmin), .rect_x_max(rxmax), .rect_y_min(rymin), .rect_y_max(rymax),
    .de(de), .hsync(hsync), .vsync(vsync), .mask(mask), .x(x), .y(y),
    .frame_done(frame_done), .busy(busy)
`ifdef MASK_STREAM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: frame position is one linear index p in 0..FRAME-1.
  bit m_run = 1'b0;
  int m_p = 0;
  bit m_fd = 1'b0;
  int m_cnt = 0;
  int m_r[4] = '{0, 0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_p = 0; m_fd = 1'b0; m_cnt = 0; m_r = '{0, 0, 0, 0};
    end else begin
      m_fd = 1'b0;
      if (ce) begin
        if (!m_run) begin
          if (enable) begin
            m_run = 1'b1; m_p = 0;
            m_r = '{int'(rxmin), int'(rxmax), int'(rymin), int'(rymax)};
          end
        end else begin
          m_p++;
          if (m_p == FRAME) begin
            m_p = 0;
            if (enable) m_r = '{int'(rxmin), int'(rxmax), int'(rymin), int'(rymax)};
            else m_run = 1'b0;
          end else if (m_p == H * HT) begin
            m_fd = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
          end
        end
      end
    end
  end

  function automatic logic [25:0] expect_outs();
    int h, v;
    bit hs, vs, d, mk;
    h  = m_run ? m_p % HT : 0;
    v  = m_run ? m_p / HT : 0;
    hs = m_run && (h < W);
    vs = m_run && (v < H);
    d  = hs && vs;
    mk = d && (h >= m_r[0]) && (h <= m_r[1]) && (v >= m_r[2]) && (v <= m_r[3]);
    return {d, hs, vs, mk, m_fd, m_run, 10'(h), 10'(v)};
  endfunction

  int n_de, n_mask, n_fd, n_busy, cyc;
  int fd_cyc[$];

  task automatic clear_stats();
    n_de = 0; n_mask = 0; n_fd = 0; n_busy = 0;
    fd_cyc.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("outs", 32'({de, hsync, vsync, mask, frame_done, busy, x, y}), 32'(expect_outs()));
`ifdef MASK_STREAM_FRAME_CNT_EN
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
    n_de += int'(de); n_mask += int'(mask); n_fd += int'(frame_done); n_busy += int'(busy);
    if (frame_done) fd_cyc.push_back(cyc);
    cyc++;
  endtask

  task automatic set_rect(input int a, input int b, input int c, input int d);
    rxmin = 10'(a); rxmax = 10'(b); rymin = 10'(c); rymax = 10'(d);
  endtask

  initial begin
    int len;
    rst = 1'b1;
    cyc = 0;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;

    // Nominal stream: two frames with rect (2,5,1,2).
    set_rect(2, 5, 1, 2); ce = 1'b1; enable = 1'b1;
    clear_stats();
    repeat (2 * FRAME) tick();
    check_eq("de_2frames", 32'(n_de), 32'd64);
    check_eq("mask_2frames", 32'(n_mask), 32'd16);
    check_eq("fd_2frames", 32'(n_fd), 32'd2);

    // Rect change mid-frame at p=19: 4 old-rect pixels remain, next frame full.
    repeat (20) tick();
    set_rect(0, 7, 0, 3);
    clear_stats();
    repeat ((FRAME - 20) + FRAME) tick();
    check_eq("mask_midchange", 32'(n_mask), 32'd36);

    // Enable drop at v=1: frame finishes (p 15..71), then idle.
    repeat (15) tick();
    enable = 1'b0;
    clear_stats();
    repeat (FRAME) tick();
    check_eq("busy_after_drop", 32'(n_busy), 32'd57);

    // Inverted x bounds: no mask over two frames after restart.
    set_rect(6, 3, 0, 3);
    enable = 1'b1;
    clear_stats();
    repeat (2 * FRAME) tick();
    check_eq("mask_inverted", 32'(n_mask), 32'd0);
    check_eq("de_inverted", 32'(n_de), 32'd64);

    // ce toggling: a frame spans twice as many clocks.
    set_rect(2, 5, 1, 2);
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      ce = ~ce;
      tick();
    end
    len = (fd_cyc.size() >= 2) ? fd_cyc[1] - fd_cyc[0] : 0;
    check_eq("frame_len_clks", 32'(len), 32'(2 * FRAME));

    // Randomized ce, enable and rectangle updates.
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0)
        set_rect($urandom_range(0, 13), $urandom_range(0, 13), $urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset mid-line.
    ce = 1'b1; enable = 1'b1;
    repeat (5) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_outs", 32'({de, hsync, vsync, mask, frame_done, busy, x, y}), 32'd0);
`ifdef MASK_STREAM_FRAME_CNT_EN
    check_eq("async_rst_cnt", 32'(frame_cnt), 32'd0);
`endif
    #1 rst = 1'b0;
    repeat (FRAME + 1) tick();
`ifdef MASK_STREAM_FRAME_CNT_EN
    check_eq("cnt_after_frame", 32'(frame_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mask_stream_gen.md
# mask_stream_gen

Synthetic video source that drives the de/hsync/vsync/mask stream consumed by the skin-segmentation back end (bounding box, overlay). It generates raster timing for an IMG_W x IMG_H frame with configurable blanking, and asserts mask inside a programmable rectangle, so downstream blocks can be exercised with known ground truth. Sits in place of the camera/segmentation front end in bring-up builds and testbenches.

## Interface
- IMG_W, 720, active pixels per line
- IMG_H, 576, active lines per frame
- H_BLANK, 144, blank cycles per line (≥1); IMG_W+H_BLANK ≤ 1024
- V_BLANK, 49, blank lines per frame (≥1); IMG_H+V_BLANK ≤ 1024

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; all state advances only when high
- enable  in  1  run request
- rect_x_min, rect_x_max, rect_y_min, rect_y_max  in  10 each  mask rectangle, inclusive bounds
- de  out  1  active pixel
- hsync  out  1  high during active part of a line, low in horizontal blanking
- vsync  out  1  high during active lines, low during vertical blanking
- mask  out  1  pixel inside rectangle
- x, y  out  10 each  current raster position
- frame_done  out  1  one-clk pulse at end of active frame
- busy  out  1  high in RUN

## Operation
- Two states: IDLE, RUN. 10-bit counters h (0..IMG_W+H_BLANK-1), v (0..IMG_H+V_BLANK-1).
- IDLE: h=v=0, all outputs 0. On a ce edge with enable=1: go RUN, h=v=0, latch rect_* into shadow registers.
- RUN, each ce edge: h increments; at h=IMG_W+H_BLANK-1 h wraps to 0 and v increments; at last position of frame (both at max) v wraps to 0.
- At frame wrap: if enable=1 relatch rect_* and continue; else go IDLE. Deasserting enable never truncates a frame.
- Decode (from new counter values): hsync = h<IMG_W; vsync = v<IMG_H; de = hsync&vsync; mask = de & x_min≤h≤x_max & y_min≤v≤y_max using shadow values; x=h, y=v.
- Rect inputs change mid-frame: no effect until next frame start.
- x_min>x_max or y_min>y_max: mask stays 0 all frame. Bounds beyond image clip naturally.
- frame_done: 1 on the clk cycle following the ce edge on which vsync goes 1->0 (v enters IMG_H); 0 otherwise, including when ce is low.
- rst asserted any time: immediately IDLE, counters, shadows and all outputs 0.

## Timing
- All outputs registered; updated on the same edge as the counters (no extra pipeline stage).
- First de=1 on the ce edge that enters RUN (pixel 0,0).
- ce low: all outputs and state hold; frame_done deasserts after one clk.
- Frame period: (IMG_W+H_BLANK)*(IMG_H+V_BLANK) ce edges; line period IMG_W+H_BLANK ce edges.
- frame_done coincides with downstream vsync-falling-edge detection one cycle later, matching end-of-frame latching in consumers.
- Reset values: de, hsync, vsync, mask, frame_done, busy = 0; x, y = 0.

## Configuration
- MASK_STREAM_FRAME_CNT_EN defined: adds output frame_cnt [15:0], reset 0, incremented with each frame_done pulse, wraps 0xFFFF->0, holds in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- IMG_W=8, IMG_H=4, H_BLANK=4, V_BLANK=2, ce=1, enable=1, rect (2,5,1,2) -> 72-cycle frame; de high 32 cycles/frame; mask high exactly 8 cycles at x 2..5, y 1..2; frame_done once per 72 cycles, one cycle after vsync falls.
- Same config, enable dropped at v=1 -> frame completes all 72 positions, then busy=0 and outputs 0; re-enable restarts at (0,0).
- rect changed mid-frame to (0,7,0,3) -> current frame keeps old mask; next frame mask = de (32 cycles).
- rect x_min=6, x_max=3 -> mask never asserts over two frames.
- ce toggling 1,0,1,0 -> outputs hold on ce=0 edges; frame length 144 clks; frame_done 1 clk wide.
- rst pulsed asynchronously mid-line (not at edge) -> outputs 0 immediately; with MASK_STREAM_FRAME_CNT_EN, frame_cnt reads 0 then 1 after next full frame.
